rf_wport_arbiter: RTL and testbench

// - Shares the single regfile write port between the in-order WB stage and the long-latency unit (LU, mul/div).
// - Holds LU results in a 1-entry buffer and arbitrates them onto the port.
// - Keeps a per-register pending scoreboard so ID stalls on RAW/WAW hazards against outstanding LU results.
// - Its rf_* outputs drive the regfile write port and the ID "wb" forwarding path.

---
 rtl/rf_wport_arbiter.sv | 147 ++++++++++++++
 tb/tb_rf_wport_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// Shares the regfile write port between WB and a buffered long-latency unit, with a pending-register scoreboard.
// Optional macro RF_ARB_BYPASS_EN lets an LU result skip the buffer when the port is idle.
module rf_wport_arbiter #(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_rd_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]   wb_rd_wdata,
  output logic              wb_stall,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_AW-1:0] lu_rd_addr,
  input  logic [XLEN-1:0]   lu_rd_wdata,
  input  logic              sb_set,
  input  logic [REG_AW-1:0] sb_set_addr,
  input  logic [REG_AW-1:0] dec_rs1_addr,
  input  logic [REG_AW-1:0] dec_rs2_addr,
  input  logic [REG_AW-1:0] dec_rd_addr,
  output logic              id_sb_stall,
  output logic              rf_write,
  output logic [REG_AW-1:0] rf_addr,
  output logic [XLEN-1:0]   rf_wdata
);

  localparam int NREG  = 1 << REG_AW;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [2:0] ST_EMPTY = 3'b001;
  localparam logic [2:0] ST_HELD  = 3'b010;
  localparam logic [2:0] ST_FORCE = 3'b100;

  logic [2:0]        state, state_nxt;
  logic [REG_AW-1:0] buf_addr;
  logic [XLEN-1:0]   buf_data;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;
  logic [NREG-1:0]   pending, pending_nxt;

  logic in_empty, in_held, in_force;
  logic buf_drain, lu_bypass, lu_accept, lu_load, force_due;
  logic              lu_wr;
  logic [REG_AW-1:0] lu_wr_addr;

  assign in_empty = (state == ST_EMPTY);
  assign in_held  = (state == ST_HELD);
  assign in_force = (state == ST_FORCE);

  // Writes are suppressed while reset is asserted so a held result is discarded, not written.
  assign buf_drain = ~rst & ((in_held & ~wb_rd_write) | in_force);
  assign lu_ready  = in_empty | buf_drain;
  assign lu_accept = ~rst & lu_valid & lu_ready;

`ifdef RF_ARB_BYPASS_EN
  assign lu_bypass = ~rst & in_empty & ~wb_rd_write & lu_valid;
`else
  assign lu_bypass = 1'b0;
`endif

  assign lu_load    = lu_accept & ~lu_bypass;
  assign lu_wr      = buf_drain | lu_bypass;
  assign lu_wr_addr = lu_bypass ? lu_rd_addr : buf_addr;

  assign force_due = (int'(starve_cnt) + 1) >= (STARVE_LIMIT - 1);

  always_comb begin
    rf_write = 1'b0;
    rf_addr  = wb_rd_addr;
    rf_wdata = wb_rd_wdata;
    if (lu_bypass) begin
      rf_write = 1'b1;
      rf_addr  = lu_rd_addr;
      rf_wdata = lu_rd_wdata;
    end else if (buf_drain) begin
      rf_write = 1'b1;
      rf_addr  = buf_addr;
      rf_wdata = buf_data;
    end else begin
      rf_write = ~rst & wb_rd_write;
    end
  end

  assign wb_stall = ~rst & in_force & wb_rd_write;

  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    unique case (state)
      ST_EMPTY: begin
        starve_cnt_nxt = '0;
        if (lu_load) state_nxt = ST_HELD;
      end
      ST_HELD: begin
        if (buf_drain) begin
          starve_cnt_nxt = '0;
          state_nxt      = lu_load ? ST_HELD : ST_EMPTY;
        end else begin
          starve_cnt_nxt = starve_cnt + CNT_W'(1);
          if (force_due) state_nxt = ST_FORCE;
        end
      end
      ST_FORCE: begin
        starve_cnt_nxt = '0;
        state_nxt      = lu_load ? ST_HELD : ST_EMPTY;
      end
      default: begin
        starve_cnt_nxt = '0;
        state_nxt      = ST_EMPTY;
      end
    endcase
  end

  // Set is applied after clear so an issue racing a drain to the same register stays pending.
  always_comb begin
    pending_nxt = pending;
    if (lu_wr)  pending_nxt[lu_wr_addr]  = 1'b0;
    if (sb_set) pending_nxt[sb_set_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  function automatic logic hazard(input logic [REG_AW-1:0] a);
    return pending[a] & ~(lu_wr & (lu_wr_addr == a));
  endfunction

  assign id_sb_stall = hazard(dec_rs1_addr) | hazard(dec_rs2_addr) | hazard(dec_rd_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      starve_cnt <= '0;
      pending    <= '0;
      buf_addr   <= '0;
      buf_data   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      pending    <= pending_nxt;
      if (lu_load) begin
        buf_addr <= lu_rd_addr;
        buf_data <= lu_rd_wdata;
      end
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed self-checking bench for rf_wport_arbiter (STARVE_LIMIT=4); expectations follow RF_ARB_BYPASS_EN.
module tb_rf_wport_arbiter;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
`ifdef RF_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_rd_write;
  logic [REG_AW-1:0] wb_rd_addr;
  logic [XLEN-1:0]   wb_rd_wdata;
  logic              wb_stall;
  logic              lu_valid;
  logic              lu_ready;
  logic [REG_AW-1:0] lu_rd_addr;
  logic [XLEN-1:0]   lu_rd_wdata;
  logic              sb_set;
  logic [REG_AW-1:0] sb_set_addr;
  logic [REG_AW-1:0] dec_rs1_addr;
  logic [REG_AW-1:0] dec_rs2_addr;
  logic [REG_AW-1:0] dec_rd_addr;
  logic              id_sb_stall;
  logic              rf_write;
  logic [REG_AW-1:0] rf_addr;
  logic [XLEN-1:0]   rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rf_wport_arbiter #(.XLEN(XLEN), .REG_AW(REG_AW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_rd_write(wb_rd_write), .wb_rd_addr(wb_rd_addr), .wb_rd_wdata(wb_rd_wdata),
    .wb_stall(wb_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd_addr(lu_rd_addr), .lu_rd_wdata(lu_rd_wdata),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr), .dec_rd_addr(dec_rd_addr),
    .id_sb_stall(id_sb_stall),
    .rf_write(rf_write), .rf_addr(rf_addr), .rf_wdata(rf_wdata)
  );

  // Inputs change just after the falling edge; one step crosses exactly one rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; lu_valid = 1'b1; lu_rd_addr = 5'd3; lu_rd_wdata = 32'h5555_AAAA;
    step(); #1;
    n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_lu_ready: got %b want 1", lu_ready); end
    n_checks++; if (rf_write !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rf_write: got %b want 0", rf_write); end
    n_checks++; if (id_sb_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_id_stall: got %b want 0", id_sb_stall); end
    n_checks++; if (wb_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wb_stall: got %b want 0", wb_stall); end
    step();
    rst = 1'b0; lu_valid = 1'b0; #1;
    n_checks++; if (rf_write !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_buf_empty: got rf_write=%b want 0", rf_write); end
    n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_after_ready: got %b want 1", lu_ready); end
    step();
  endtask

  task automatic test_lu_basic();
    sb_set = 1'b1; sb_set_addr = 5'd5;
    step();
    sb_set = 1'b0; dec_rs1_addr = 5'd5;
    lu_valid = 1'b1; lu_rd_addr = 5'd5; lu_rd_wdata = 32'h0000_DEAD; #1;
    n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_ready: got %b want 1", lu_ready); end
    n_checks++; if (rf_write !== BYP) begin n_fail++; $display("[TB] FAIL basic_c0_write: got %b want %b", rf_write, BYP); end
    n_checks++; if (id_sb_stall !== !BYP) begin n_fail++; $display("[TB] FAIL basic_c0_stall: got %b want %b", id_sb_stall, !BYP); end
    if (BYP) begin
      n_checks++; if (rf_addr !== 5'd5 || rf_wdata !== 32'h0000_DEAD) begin n_fail++; $display("[TB] FAIL basic_bypass_data: got x%0d=%h want x5=0000dead", rf_addr, rf_wdata); end
    end
    step();
    lu_valid = 1'b0; #1;
    n_checks++; if (rf_write !== !BYP) begin n_fail++; $display("[TB] FAIL basic_c1_write: got %b want %b", rf_write, !BYP); end
    n_checks++; if (id_sb_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_c1_stall: got %b want 0", id_sb_stall); end
    if (!BYP) begin
      n_checks++; if (rf_addr !== 5'd5 || rf_wdata !== 32'h0000_DEAD) begin n_fail++; $display("[TB] FAIL basic_drain_data: got x%0d=%h want x5=0000dead", rf_addr, rf_wdata); end
    end
    step(); #1;
    n_checks++; if (rf_write !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_c2_write: got %b want 0", rf_write); end
    n_checks++; if (id_sb_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_c2_stall: got %b want 0", id_sb_stall); end
    dec_rs1_addr = 5'd0;
    step();
  endtask

  task automatic test_starve();
    wb_rd_write = 1'b1; wb_rd_addr = 5'd10; wb_rd_wdata = 32'hA0;
    lu_valid = 1'b1; lu_rd_addr = 5'd7; lu_rd_wdata = 32'h1234; #1;
    n_checks++; if (rf_addr !== 5'd10 || rf_wdata !== 32'hA0) begin n_fail++; $display("[TB] FAIL starve_accept_wb: got x%0d=%h want x10=a0", rf_addr, rf_wdata); end
    n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL starve_accept_ready: got %b want 1", lu_ready); end
    step();
    lu_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      wb_rd_addr = 5'(10 + i); wb_rd_wdata = 32'(32'hA0 + i); #1;
      n_checks++; if (rf_write !== 1'b1 || rf_addr !== 5'(10 + i) || rf_wdata !== 32'(32'hA0 + i)) begin n_fail++; $display("[TB] FAIL starve_wb_%0d: got w=%b x%0d=%h want w=1 x%0d=%h", i, rf_write, rf_addr, rf_wdata, 10 + i, 32'hA0 + i); end
      n_checks++; if (wb_stall !== 1'b0 || lu_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL starve_held_%0d: got wb_stall=%b lu_ready=%b want 0 0", i, wb_stall, lu_ready); end
      step();
    end
    wb_rd_addr = 5'd14; wb_rd_wdata = 32'hD4; #1;
    n_checks++; if (rf_write !== 1'b1 || rf_addr !== 5'd7 || rf_wdata !== 32'h1234) begin n_fail++; $display("[TB] FAIL starve_force_data: got w=%b x%0d=%h want w=1 x7=1234", rf_write, rf_addr, rf_wdata); end
    n_checks++; if (wb_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL starve_force_stall: got %b want 1", wb_stall); end
    n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL starve_force_ready: got %b want 1", lu_ready); end
    step(); #1;
    n_checks++; if (rf_write !== 1'b1 || rf_addr !== 5'd14 || rf_wdata !== 32'hD4) begin n_fail++; $display("[TB] FAIL starve_retake: got w=%b x%0d=%h want w=1 x14=d4", rf_write, rf_addr, rf_wdata); end
    n_checks++; if (wb_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL starve_retake_stall: got %b want 0", wb_stall); end
    wb_rd_write = 1'b0; wb_rd_addr = 5'd0; wb_rd_wdata = '0;
    step();
  endtask

  task automatic test_back_to_back();
    lu_valid = 1'b1; lu_rd_addr = 5'd3; lu_rd_wdata = 32'h33; #1;
    n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_c0_ready: got %b want 1", lu_ready); end
    n_checks++; if (rf_write !== BYP) begin n_fail++; $display("[TB] FAIL b2b_c0_write: got %b want %b", rf_write, BYP); end
    step();
    lu_rd_addr = 5'd4; lu_rd_wdata = 32'h44; #1;
    n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_c1_ready: got %b want 1", lu_ready); end
    n_checks++; if (rf_write !== 1'b1 || rf_addr !== (BYP ? 5'd4 : 5'd3) || rf_wdata !== (BYP ? 32'h44 : 32'h33)) begin n_fail++; $display("[TB] FAIL b2b_c1_data: got w=%b x%0d=%h want w=1 x%0d", rf_write, rf_addr, rf_wdata, BYP ? 4 : 3); end
    step();
    lu_valid = 1'b0; #1;
    n_checks++; if (rf_write !== !BYP || rf_addr !== (BYP ? 5'd0 : 5'd4)) begin n_fail++; $display("[TB] FAIL b2b_c2: got w=%b x%0d want w=%b x%0d", rf_write, rf_addr, !BYP, BYP ? 0 : 4); end
    n_checks++; if (rf_wdata !== (BYP ? 32'h0 : 32'h44)) begin n_fail++; $display("[TB] FAIL b2b_c2_data: got %h want %h", rf_wdata, BYP ? 32'h0 : 32'h44); end
    step(); #1;
    n_checks++; if (rf_write !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_c3_idle: got %b want 0", rf_write); end
    step();
  endtask

  task automatic test_scoreboard();
    sb_set = 1'b1; sb_set_addr = 5'd9;
    step();
    sb_set = 1'b0; dec_rs2_addr = 5'd9; #1;
    n_checks++; if (id_sb_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL sb_rs2: got %b want 1", id_sb_stall); end
    dec_rs2_addr = 5'd0; dec_rd_addr = 5'd9; #1;
    n_checks++; if (id_sb_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL sb_rd_waw: got %b want 1", id_sb_stall); end
    dec_rd_addr = 5'd0; dec_rs1_addr = 5'd0; sb_set = 1'b1; sb_set_addr = 5'd0; #1;
    n_checks++; if (id_sb_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_clean: got %b want 0", id_sb_stall); end
    step();
    sb_set = 1'b0; #1;
    n_checks++; if (id_sb_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_x0_never: got %b want 0", id_sb_stall); end
    dec_rs1_addr = 5'd9; #1;
    n_checks++; if (id_sb_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL sb_rs1_still: got %b want 1", id_sb_stall); end
    dec_rs1_addr = 5'd0;
    step();
  endtask

  task automatic test_set_clear_same();
    sb_set = 1'b1; sb_set_addr = 5'd6;
    step();
    sb_set = 1'b0;
    wb_rd_write = 1'b1; wb_rd_addr = 5'd20; wb_rd_wdata = 32'h20;
    lu_valid = 1'b1; lu_rd_addr = 5'd6; lu_rd_wdata = 32'h66; #1;
    n_checks++; if (rf_addr !== 5'd20 || lu_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL sc_accept: got x%0d ready=%b want x20 ready=1", rf_addr, lu_ready); end
    step();
    wb_rd_write = 1'b0; wb_rd_addr = 5'd0; wb_rd_wdata = '0; lu_valid = 1'b0;
    sb_set = 1'b1; sb_set_addr = 5'd6; dec_rs1_addr = 5'd6; #1;
    n_checks++; if (rf_write !== 1'b1 || rf_addr !== 5'd6 || rf_wdata !== 32'h66) begin n_fail++; $display("[TB] FAIL sc_drain: got w=%b x%0d=%h want w=1 x6=66", rf_write, rf_addr, rf_wdata); end
    n_checks++; if (id_sb_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL sc_forward: got %b want 0", id_sb_stall); end
    step();
    sb_set = 1'b0; #1;
    n_checks++; if (id_sb_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL sc_set_wins: got %b want 1", id_sb_stall); end
    dec_rs1_addr = 5'd0;
    step();
  endtask

  task automatic test_reset_held();
    wb_rd_write = 1'b1; wb_rd_addr = 5'd21; wb_rd_wdata = 32'h21;
    lu_valid = 1'b1; lu_rd_addr = 5'd8; lu_rd_wdata = 32'h88;
    step();
    wb_rd_write = 1'b0; wb_rd_addr = 5'd0; wb_rd_wdata = '0; lu_valid = 1'b0;
    rst = 1'b1; #1;
    n_checks++; if (rf_write !== 1'b0) begin n_fail++; $display("[TB] FAIL rh_during_reset: got %b want 0", rf_write); end
    step();
    rst = 1'b0; dec_rs1_addr = 5'd6; #1;
    n_checks++; if (rf_write !== 1'b0 || lu_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rh_discard: got w=%b ready=%b want 0 1", rf_write, lu_ready); end
    n_checks++; if (id_sb_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL rh_pending_clear: got %b want 0", id_sb_stall); end
    step(); #1;
    n_checks++; if (rf_write !== 1'b0) begin n_fail++; $display("[TB] FAIL rh_no_late_write: got %b want 0", rf_write); end
    dec_rs1_addr = 5'd0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    wb_rd_write = 1'b0; wb_rd_addr = '0; wb_rd_wdata = '0;
    lu_valid = 1'b0; lu_rd_addr = '0; lu_rd_wdata = '0;
    sb_set = 1'b0; sb_set_addr = '0;
    dec_rs1_addr = '0; dec_rs2_addr = '0; dec_rd_addr = '0;
    test_reset();
    test_lu_basic();
    test_starve();
    test_back_to_back();
    test_scoreboard();
    test_set_clear_same();
    test_reset_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
